if_id_fetch: RTL
================

Name: if_id_fetch

Overview:
- Instruction-fetch stage plus IF/ID pipeline register; directly upstream of the decode stage, which in turn feeds bascule_id_ex.
- Owns the PC and issues single-outstanding requests to instruction memory over a req/ready handshake.
- Presents {PC+4, instruction, valid} to decode.
- Supports hazard stall and branch/jump redirect from execute, squashing any wrong-path fetch still in flight.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, instruction word driven on out_instruction when out_valid=0.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  reset, synchronous, active-low (0 = reset, sampled on posedge clk).
imem_req  output  1  fetch request; held high until imem_ready.
imem_addr  output  32  fetch address; stable while imem_req=1.
imem_ready  input  1  response valid this cycle; meaningful only while imem_req=1.
imem_rdata  input  32  instruction word, valid with imem_ready.
stall  input  1  hazard unit: hold IF/ID contents and PC.
redirect  input  1  branch taken or jump, resolved in execute.
redirect_pc  input  32  new PC target, valid with redirect.
out_pc  output  32  PC+4 of the instruction held in IF/ID.
out_instruction  output  32  instruction held in IF/ID.
out_valid  output  1  IF/ID holds a real instruction.
perf_fetched  output  32  retired-fetch counter (optional feature).
perf_stalls  output  32  stall-cycle counter (optional feature).

Behaviour:
- Reset (rst=0 at posedge):
  - pc=RESET_PC; state=FETCH; imem_req=0 during the reset cycle; drop flag=0.
  - out_pc=0, out_instruction=NOP_INSTR, out_valid=0; buffer cleared; perf counters=0.
- Reset overrides every other input, including mid-access. A pending imem response is abandoned; the memory is required to accept that.
- States:
  - FETCH: imem_req=1, imem_addr=pc.
  - BUFFERED: response captured during a stall; imem_req=0.
  - DRAIN: wrong-path request still in flight; imem_req=1, imem_addr=old pc; response discarded.
- Cycle rules, in priority order:
  1. Redirect (redirect=1): pc<=redirect_pc; out_valid<=0, out_instruction<=NOP_INSTR; buffer discarded. State becomes FETCH, except if state=FETCH with imem_ready=0, where it becomes DRAIN (handshake must complete). Redirect beats stall.
  2. FETCH, imem_ready=1, stall=0: IF/ID <= {pc+4, imem_rdata, 1}; pc<=pc+4; stay FETCH. Back-to-back: one instruction per cycle with zero-wait memory.
  3. FETCH, imem_ready=1, stall=1: capture {pc+4, imem_rdata} into buffer; pc<=pc+4; go BUFFERED; IF/ID unchanged.
  4. FETCH, imem_ready=0: hold everything; stall has no effect on an in-flight request.
  5. BUFFERED, stall=0: IF/ID <= {buffer, valid=1}; go FETCH.
  6. BUFFERED, stall=1: hold.
  7. DRAIN, imem_ready=1: discard data; go FETCH (pc already = redirect target).
  8. DRAIN, redirect again: pc<=new redirect_pc; stay DRAIN.
- While stall=1 and no redirect, out_* are held bit-for-bit.
- PC arithmetic: 32-bit, wraps 32'hFFFF_FFFC -> 0. Low two bits of redirect_pc are passed through unchecked.
- Redirect latency: first request to redirect_pc appears the cycle after redirect (FETCH path), or the cycle after drain completes.

Optional Feature:
IF_ID_PERF_CNT_EN
- Defined:
  - perf_fetched increments on every IF/ID load with valid=1 (rules 2 and 5).
  - perf_stalls increments every cycle with stall=1 and rst=1.
  - Both are 32-bit, wrapping, and cleared by reset.
- Undefined: both ports driven constant 0; no counter flops synthesized.

Test Plan:
- Reset, then zero-wait imem returning 0x11,0x22,0x33 -> out_instruction 0x11/0x22/0x33 on consecutive cycles, out_pc 4/8/12, out_valid=1.
- imem_ready delayed 3 cycles at pc=8 -> imem_addr=8 held for 4 cycles, out_* unchanged, then 0x33 loaded with out_pc=12.
- stall=1 while imem_ready=1 with 0xAA at pc=16 -> imem_req=0 next cycle, out_* held; stall drop -> out_instruction=0xAA, out_pc=20, then request at pc=20.
- redirect=1, redirect_pc=0x100, with request at pc=24 pending (ready=0) -> out_valid=0, DRAIN; ready returns 0xBB and it is discarded; next imem_addr=0x100; out_valid never shows 0xBB.
- redirect and stall asserted together -> redirect wins: out_valid=0, next fetch at redirect_pc; stall afterwards holds the bubble.
- rst=0 mid-DRAIN with IF_ID_PERF_CNT_EN defined -> all outputs reset values, perf counters 0, first request at RESET_PC after rst=1.

Source files
------------

// File: rtl/if_id_fetch.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | if_id_fetch : instruction fetch stage with IF/ID pipeline register.     |
// | Optional perf counters enabled by defining IF_ID_PERF_CNT_EN.           |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module if_id_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] out_pc,
    output logic [31:0] out_instruction,
    output logic        out_valid,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stalls
);

    typedef enum logic [1:0] {
        ST_FETCH    = 2'd0,
        ST_BUFFERED = 2'd1,
        ST_DRAIN    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        out_pc_d     = out_pc_q;
        out_instr_d  = out_instr_q;
        out_valid_d  = out_valid_q;
        buf_pc_d     = buf_pc_q;
        buf_instr_d  = buf_instr_q;

        if (redirect) begin
            pc_d        = redirect_pc;
            out_valid_d = 1'b0;
            out_instr_d = NOP_INSTR;
            buf_pc_d    = 32'd0;
            buf_instr_d = NOP_INSTR;
            // An outstanding request must still complete its handshake.
            if ((state_q != ST_BUFFERED) && !imem_ready) begin
                state_d = ST_DRAIN;
                if (state_q == ST_FETCH) begin
                    drain_addr_d = pc_q;
                end
            end else begin
                state_d = ST_FETCH;
            end
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (imem_ready) begin
                        pc_d = pc_plus4;
                        if (stall) begin
                            buf_pc_d    = pc_plus4;
                            buf_instr_d = imem_rdata;
                            state_d     = ST_BUFFERED;
                        end else begin
                            out_pc_d    = pc_plus4;
                            out_instr_d = imem_rdata;
                            out_valid_d = 1'b1;
                        end
                    end
                end
                ST_BUFFERED: begin
                    if (!stall) begin
                        out_pc_d    = buf_pc_q;
                        out_instr_d = buf_instr_q;
                        out_valid_d = 1'b1;
                        state_d     = ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (imem_ready) begin
                        state_d = ST_FETCH;
                    end
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            drain_addr_q <= 32'd0;
            out_pc_q     <= 32'd0;
            out_instr_q  <= NOP_INSTR;
            out_valid_q  <= 1'b0;
            buf_pc_q     <= 32'd0;
            buf_instr_q  <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            out_pc_q     <= out_pc_d;
            out_instr_q  <= out_instr_d;
            out_valid_q  <= out_valid_d;
            buf_pc_q     <= buf_pc_d;
            buf_instr_q  <= buf_instr_d;
        end
    end

    // Request is suppressed in the reset cycle itself, not just after it.
    assign imem_req        = rst && (state_q != ST_BUFFERED);
    assign imem_addr       = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
    assign out_pc          = out_pc_q;
    assign out_instruction = out_instr_q;
    assign out_valid       = out_valid_q;

`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stalls_q, perf_stalls_d;
    logic        fetch_load;

    always_comb begin
        fetch_load = !redirect && !stall &&
                     (((state_q == ST_FETCH) && imem_ready) || (state_q == ST_BUFFERED));
        perf_fetched_d = perf_fetched_q + (fetch_load ? 32'd1 : 32'd0);
        perf_stalls_d  = perf_stalls_q + (stall ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_fetched_q <= 32'd0;
            perf_stalls_q  <= 32'd0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stalls_q  <= perf_stalls_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stalls  = perf_stalls_q;
`else
    assign perf_fetched = 32'd0;
    assign perf_stalls  = 32'd0;
`endif

endmodule
`default_nettype wire
